mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between instruction fetch (IF, read-only) and the load/store unit (LS, read/write with byte mask).
- Sits between the fetch stage / LSU and the unified instruction+data RAM.
- Each requester gets exclusive use of the port for a whole transaction, sequenced by an FSM.
- Handles a fixed memory read latency and selects fixed-priority or round-robin arbitration.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/LS requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [31:0]       o_if_rdata;

    logic              i_ls_req;
    logic              i_ls_we;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [31:0]       i_ls_wdata;
    logic [3:0]        i_ls_bmask;
    logic              o_ls_gnt;
    logic              o_ls_rvalid;
    logic [31:0]       o_ls_rdata;

    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-3:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_bmask;
    logic [31:0]       i_mem_rdata;
    logic              o_busy;

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_rdata,
        input  o_busy
    );

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_rdata,
        output o_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int LS_PRIO = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t     state;
    logic       owner_ls;
    logic [3:0] lat_cnt;
    logic       ls_wins;

    // owner_ls doubles as the round-robin "last winner" flag: it only changes at a grant.
    always_comb begin
        ls_wins = bus.i_ls_req && (!bus.i_if_req || (LS_PRIO != 0) || !owner_ls);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= IDLE;
            owner_ls        <= 1'b0;
            lat_cnt         <= 4'd0;
            bus.o_if_gnt    <= 1'b0;
            bus.o_if_rvalid <= 1'b0;
            bus.o_if_rdata  <= 32'd0;
            bus.o_ls_gnt    <= 1'b0;
            bus.o_ls_rvalid <= 1'b0;
            bus.o_ls_rdata  <= 32'd0;
            bus.o_mem_en    <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= 32'd0;
            bus.o_mem_bmask <= 4'd0;
            bus.o_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_if_req || bus.i_ls_req) begin
                        state        <= CMD;
                        owner_ls     <= ls_wins;
                        bus.o_busy   <= 1'b1;
                        bus.o_mem_en <= 1'b1;
                        bus.o_ls_gnt <= ls_wins;
                        bus.o_if_gnt <= !ls_wins;
                        if (ls_wins) begin
                            bus.o_mem_we    <= bus.i_ls_we;
                            bus.o_mem_addr  <= bus.i_ls_addr[ADDR_W-1:2];
                            bus.o_mem_wdata <= bus.i_ls_we ? bus.i_ls_wdata : 32'd0;
                            bus.o_mem_bmask <= bus.i_ls_we ? bus.i_ls_bmask : 4'b1111;
                        end else begin
                            bus.o_mem_we    <= 1'b0;
                            bus.o_mem_addr  <= bus.i_if_addr[ADDR_W-1:2];
                            bus.o_mem_wdata <= 32'd0;
                            bus.o_mem_bmask <= 4'b1111;
                        end
                    end
                end
                CMD: begin
                    bus.o_mem_en <= 1'b0;
                    bus.o_mem_we <= 1'b0;
                    bus.o_if_gnt <= 1'b0;
                    bus.o_ls_gnt <= 1'b0;
                    if (bus.o_mem_we) begin
                        state      <= IDLE;
                        bus.o_busy <= 1'b0;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= 4'(MEM_LAT);
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        state <= RESP;
                        if (owner_ls) begin
                            bus.o_ls_rdata  <= bus.i_mem_rdata;
                            bus.o_ls_rvalid <= 1'b1;
                        end else begin
                            bus.o_if_rdata  <= bus.i_mem_rdata;
                            bus.o_if_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state           <= IDLE;
                    bus.o_busy      <= 1'b0;
                    bus.o_if_rvalid <= 1'b0;
                    bus.o_ls_rvalid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word-addressed RAM: the byte-offset bits are intentionally ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.i_if_addr[1:0], bus.i_ls_addr[1:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (priority and round-robin instances)
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int MLA = 2;
    localparam int MLB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    mem_port_arbiter_if #(.ADDR_W(AW)) ia ();
    mem_port_arbiter_if #(.ADDR_W(AW)) ib ();

    mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(MLA), .LS_PRIO(1)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .bus(ia)
    );
    mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(MLB), .LS_PRIO(0)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .bus(ib)
    );

    function automatic logic [31:0] pat(int i);
        return (i == 4) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i) * 32'h00010203;
    endfunction

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] pipe_a [MLA];
    logic [31:0] pipe_b [MLB];

    always @(posedge clk) begin
        if (rst_a) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= pat(i);
        end else if (ia.o_mem_en && ia.o_mem_we) begin
            for (int k = 0; k < 4; k++)
                if (ia.o_mem_bmask[k]) mem_a[ia.o_mem_addr[5:0]][8*k +: 8] <= ia.o_mem_wdata[8*k +: 8];
        end
        pipe_a[0] <= ia.o_mem_en ? mem_a[ia.o_mem_addr[5:0]] : 32'hBAD0BAD0;
        for (int k = 1; k < MLA; k++) pipe_a[k] <= pipe_a[k-1];
    end

    always @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= pat(i);
        end else if (ib.o_mem_en && ib.o_mem_we) begin
            for (int k = 0; k < 4; k++)
                if (ib.o_mem_bmask[k]) mem_b[ib.o_mem_addr[5:0]][8*k +: 8] <= ib.o_mem_wdata[8*k +: 8];
        end
        pipe_b[0] <= ib.o_mem_en ? mem_b[ib.o_mem_addr[5:0]] : 32'hBAD0BAD0;
        for (int k = 1; k < MLB; k++) pipe_b[k] <= pipe_b[k-1];
    end

    assign ia.i_mem_rdata = pipe_a[MLA-1];
    assign ib.i_mem_rdata = pipe_b[MLB-1];

    logic any_out_a, any_out_b;
    assign any_out_a = |{ia.o_if_gnt, ia.o_if_rvalid, ia.o_if_rdata, ia.o_ls_gnt, ia.o_ls_rvalid,
                         ia.o_ls_rdata, ia.o_mem_en, ia.o_mem_we, ia.o_mem_addr, ia.o_mem_wdata,
                         ia.o_mem_bmask, ia.o_busy};
    assign any_out_b = |{ib.o_if_gnt, ib.o_if_rvalid, ib.o_if_rdata, ib.o_ls_gnt, ib.o_ls_rvalid,
                         ib.o_ls_rdata, ib.o_mem_en, ib.o_mem_we, ib.o_mem_addr, ib.o_mem_wdata,
                         ib.o_mem_bmask, ib.o_busy};

    typedef struct {
        bit          ls;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and retire any read response against the scoreboards.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (ia.o_if_rvalid || ia.o_ls_rvalid) begin
            if (qa.size() == 0) begin
                chk("a_spurious_rvalid", 64'({ia.o_ls_rvalid, ia.o_if_rvalid}), 64'(0));
            end else begin
                e = qa.pop_front();
                chk("a_rv_owner", 64'({ia.o_ls_rvalid, ia.o_if_rvalid}), e.ls ? 64'(2) : 64'(1));
                chk("a_rdata", 64'(e.ls ? ia.o_ls_rdata : ia.o_if_rdata), 64'(e.data));
            end
        end
        if (ib.o_if_rvalid || ib.o_ls_rvalid) begin
            if (qb.size() == 0) begin
                chk("b_spurious_rvalid", 64'({ib.o_ls_rvalid, ib.o_if_rvalid}), 64'(0));
            end else begin
                e = qb.pop_front();
                chk("b_rv_owner", 64'({ib.o_ls_rvalid, ib.o_if_rvalid}), e.ls ? 64'(2) : 64'(1));
                chk("b_rdata", 64'(e.ls ? ib.o_ls_rdata : ib.o_if_rdata), 64'(e.data));
            end
        end
    endtask

    task automatic wait_gnt_a(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(ia.o_if_gnt || ia.o_ls_gnt) && n < 30);
        chk("a_gnt_seen", 64'(ia.o_if_gnt || ia.o_ls_gnt), 64'(1));
    endtask

    task automatic wait_gnt_b(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(ib.o_if_gnt || ib.o_ls_gnt) && n < 30);
        chk("b_gnt_seen", 64'(ib.o_if_gnt || ib.o_ls_gnt), 64'(1));
    endtask

    initial begin
        int n;
        bit ls;
        int w;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.i_if_req = 1'b1; ia.i_if_addr = 32'h40;
        ia.i_ls_req = 1'b1; ia.i_ls_we = 1'b0; ia.i_ls_addr = 32'h44;
        ia.i_ls_wdata = 32'd0; ia.i_ls_bmask = 4'd0;
        ib.i_if_req = 1'b1; ib.i_if_addr = 32'h48;
        ib.i_ls_req = 1'b1; ib.i_ls_we = 1'b0; ib.i_ls_addr = 32'h4C;
        ib.i_ls_wdata = 32'd0; ib.i_ls_bmask = 4'd0;

        repeat (2) begin
            tick();
            chk("a_reset_outs", 64'(any_out_a), 64'(0));
            chk("b_reset_outs", 64'(any_out_b), 64'(0));
            chk("a_reset_busy", 64'(ia.o_busy), 64'(0));
        end

        // First tie after reset: LS wins in both modes.
        qa.push_back('{1'b1, pat(17)});
        qb.push_back('{1'b1, pat(19)});
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        chk("a_first_gnt", 64'({ia.o_ls_gnt, ia.o_if_gnt, ia.o_mem_en}), 64'(3'b101));
        chk("a_first_addr", 64'(ia.o_mem_addr), 64'(17));
        chk("b_first_gnt", 64'({ib.o_ls_gnt, ib.o_if_gnt, ib.o_mem_en}), 64'(3'b101));
        chk("b_first_addr", 64'(ib.o_mem_addr), 64'(19));
        ia.i_ls_req = 1'b0;
        ib.i_ls_req = 1'b0;
        ib.i_if_req = 1'b0;
        qa.push_back('{1'b0, pat(16)});
        wait_gnt_a(n);
        chk("a_prio_if_gap", 64'(n), 64'(MLA + 3));
        chk("a_prio_if_gnt", 64'({ia.o_ls_gnt, ia.o_if_gnt}), 64'(2'b01));
        ia.i_if_req = 1'b0;
        repeat (MLA + 3) tick();
        chk("a_idle_busy", 64'(ia.o_busy), 64'(0));
        chk("ab_drained", 64'(qa.size() + qb.size()), 64'(0));

        // IF read of the word holding 0xDEADBEEF.
        ia.i_if_addr = 32'h10;
        ia.i_if_req  = 1'b1;
        qa.push_back('{1'b0, 32'hDEADBEEF});
        wait_gnt_a(n);
        chk("a_if_gnt_lat", 64'(n), 64'(1));
        chk("a_if_cmd", 64'({ia.o_if_gnt, ia.o_ls_gnt, ia.o_mem_en, ia.o_mem_we}), 64'(4'b1010));
        chk("a_if_addr", 64'(ia.o_mem_addr), 64'(4));
        ia.i_if_req = 1'b0;
        repeat (MLA + 1) tick();
        chk("a_if_rvalid_time", 64'({ia.o_if_rvalid, ia.o_ls_rvalid}), 64'(2'b10));
        chk("a_if_rdata", 64'(ia.o_if_rdata), 64'(32'hDEADBEEF));
        tick();
        chk("a_if_done_busy", 64'(ia.o_busy), 64'(0));

        // LS masked write.
        ia.i_ls_we = 1'b1; ia.i_ls_addr = 32'h20;
        ia.i_ls_wdata = 32'h12345678; ia.i_ls_bmask = 4'b0011;
        ia.i_ls_req = 1'b1;
        wait_gnt_a(n);
        chk("a_wr_gnt_lat", 64'(n), 64'(1));
        chk("a_wr_cmd", 64'({ia.o_ls_gnt, ia.o_if_gnt, ia.o_mem_en, ia.o_mem_we}), 64'(4'b1011));
        chk("a_wr_addr", 64'(ia.o_mem_addr), 64'(8));
        chk("a_wr_wdata", 64'(ia.o_mem_wdata), 64'(32'h12345678));
        chk("a_wr_bmask", 64'(ia.o_mem_bmask), 64'(4'b0011));
        ia.i_ls_req = 1'b0;
        ia.i_ls_we  = 1'b0;
        tick();
        chk("a_wr_after", 64'({ia.o_busy, ia.o_mem_en, ia.o_mem_we}), 64'(0));
        repeat (4) tick();

        // LS read-back shows only the masked bytes changed.
        ia.i_ls_bmask = 4'b0000;
        ia.i_ls_req   = 1'b1;
        qa.push_back('{1'b1, (pat(8) & 32'hFFFF0000) | 32'h00005678});
        wait_gnt_a(n);
        chk("a_rd_bmask", 64'(ia.o_mem_bmask), 64'(4'b1111));
        chk("a_rd_wdata_we", 64'({ia.o_mem_we, ia.o_mem_wdata}), 64'(0));
        ia.i_ls_req = 1'b0;
        repeat (MLA + 1) tick();
        chk("a_ls_rvalid_time", 64'({ia.o_ls_rvalid, ia.o_if_rvalid}), 64'(2'b10));
        tick();

        // Reset during WAIT discards the pending response.
        ia.i_ls_addr = 32'h24;
        ia.i_ls_req  = 1'b1;
        wait_gnt_a(n);
        ia.i_ls_req = 1'b0;
        tick();
        chk("a_in_wait_busy", 64'(ia.o_busy), 64'(1));
        rst_a = 1'b1;
        tick();
        chk("a_midrst_outs", 64'(any_out_a), 64'(0));
        chk("a_midrst_rdata", 64'(ia.o_ls_rdata), 64'(0));
        rst_a = 1'b0;
        repeat (MLA + 2) tick();
        chk("a_midrst_quiet", 64'({ia.o_ls_rvalid, ia.o_busy}), 64'(0));

        // Round-robin instance: both requesters keep re-requesting.
        rst_b = 1'b1;
        ib.i_if_addr = 32'h60;
        ib.i_ls_addr = 32'h70;
        tick();
        rst_b = 1'b0;
        ib.i_if_req = 1'b1;
        ib.i_ls_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt_b(n);
            ls = (i % 2 == 0);
            chk("b_rr_gap", 64'(n), (i == 0) ? 64'(1) : 64'(MLB + 3));
            chk("b_rr_order", 64'({ib.o_ls_gnt, ib.o_if_gnt}), ls ? 64'(2'b10) : 64'(2'b01));
            w = int'(ls ? ib.i_ls_addr[31:2] : ib.i_if_addr[31:2]);
            qb.push_back('{ls, pat(w)});
            if (ls) ib.i_ls_addr = ib.i_ls_addr + 32'd4;
            else    ib.i_if_addr = ib.i_if_addr + 32'd4;
        end
        ib.i_if_req = 1'b0;
        ib.i_ls_req = 1'b0;
        repeat (6) tick();
        chk("final_drained", 64'(qa.size() + qb.size()), 64'(0));
        chk("final_busy", 64'({ia.o_busy, ib.o_busy}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
